// File: rtl/vec_result_store.sv
// Result write-back: serializes the A3/A4 vector registers into word memory.
// Beats use a valid/ready handshake, and done pulses once per command.
module vec_result_store #(
    parameter int REG_W  = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [REG_W-1:0]  A3,
    input  logic [REG_W-1:0]  A4,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata
);

    localparam int WORDS = REG_W / WORD_W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [REG_W-1:0]  a3_q, a4_q;
    logic [ADDR_W-1:0] base_q;
    logic              a4_en_q;
    logic              hi_q;
    logic [CW-1:0]     idx_q;
    logic              last_word;
    logic              accept;
    logic [ADDR_W-1:0] offset;
    logic [WORD_W-1:0] word;

    assign last_word = (idx_q == CW'(WORDS - 1));
    assign accept    = (state == WRITE) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (sel == 2'b00) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept && last_word && (hi_q || !a4_en_q)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // hi_q selects the A4 half; a command with only A4 starts there directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a3_q    <= '0;
            a4_q    <= '0;
            base_q  <= '0;
            a4_en_q <= 1'b0;
            hi_q    <= 1'b0;
            idx_q   <= '0;
        end else if (state == IDLE && start && sel != 2'b00) begin
            a3_q    <= A3;
            a4_q    <= A4;
            base_q  <= base_addr;
            a4_en_q <= sel[1];
            hi_q    <= ~sel[0];
            idx_q   <= '0;
        end else if (accept) begin
            if (last_word) begin
                idx_q <= '0;
                hi_q  <= 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign offset = hi_q ? ADDR_W'(WORDS) + ADDR_W'(idx_q) : ADDR_W'(idx_q);
    assign word   = hi_q ? a4_q[idx_q*WORD_W +: WORD_W]
                         : a3_q[idx_q*WORD_W +: WORD_W];

    assign busy      = (state == WRITE);
    assign mem_we    = busy;
    assign done      = (state == DONE);
    assign mem_addr  = busy ? base_q + offset : '0;
    assign mem_wdata = busy ? word : '0;

endmodule
